risc16b_io_responder: RTL

RISC16B_IO_RESPONDER -- requirements
Module: risc16b_io_responder

---
 rtl/risc16b_io_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/risc16b_io_responder.sv
// risc16b_io_responder
// Memory-mapped I/O page for the RISC16B data bus. When d_addr[15:8] matches
// PAGE the block claims the access (io_sel) and decodes d_addr[7:1]:
//   0x00 LED    rw, byte-lane writable
//   0x01 TIMER  rw, free-running up-counter, lane writes override the increment
//   0x02 TXDATA w pushes a full word into the output FIFO, r peeks the head
//   0x03 STATUS {8'h00, count[5:0], ovf, empty}; writing bit1 on lane [7:0] clears ovf
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   d_addr/d_oe/d_we    CPU data bus address, read enable, byte write enables
//   d_dout / d_din      CPU write data / combinational read data
//   io_sel              page hit, lets the external memory stay quiet
//   led                 LED register
//   out_data/out_valid  FIFO head and not-empty flag
//   out_ready           sink accepts the head word
module risc16b_io_responder #(
    parameter logic [7:0] PAGE       = 8'h7f,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_addr,
    input  logic        d_oe,
    input  logic [1:0]  d_we,
    input  logic [15:0] d_dout,
    output logic [15:0] d_din,
    output logic        io_sel,
    output logic [15:0] led,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [6:0] OFF_LED    = 7'h00;
    localparam logic [6:0] OFF_TIMER  = 7'h01;
    localparam logic [6:0] OFF_TXDATA = 7'h02;
    localparam logic [6:0] OFF_STATUS = 7'h03;

    logic [15:0]   led_q, led_d;
    logic [15:0]   timer_q, timer_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   mem_q [FIFO_DEPTH];

    logic [6:0]  off;
    logic        empty, full;
    logic        led_wr, timer_wr, push_req, push_ok, pop, drop, ovf_clr;
    logic [5:0]  cnt6;
    logic [15:0] status;

    assign io_sel    = (d_addr[15:8] == PAGE);
    assign off       = d_addr[7:1];
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign led       = led_q;

    assign led_wr   = io_sel && (off == OFF_LED);
    assign timer_wr = io_sel && (off == OFF_TIMER) && (d_we != 2'b00);
    assign push_req = io_sel && (off == OFF_TXDATA) && (d_we == 2'b11);
    assign ovf_clr  = io_sel && (off == OFF_STATUS) && d_we[1] && d_dout[1];
    assign pop      = out_valid && out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Count is 0..FIFO_DEPTH; only its low six bits are visible in STATUS.
    assign cnt6   = 6'(count_q);
    assign status = {8'h00, cnt6, ovf_q, empty};

    always_comb begin
        d_din = 16'h0000;
        if (io_sel && d_oe) begin
            case (off)
                OFF_LED:    d_din = led_q;
                OFF_TIMER:  d_din = timer_q;
                OFF_TXDATA: d_din = out_data;
                OFF_STATUS: d_din = status;
                default:    d_din = 16'h0000;
            endcase
        end
    end

    always_comb begin
        led_d = led_q;
        if (led_wr && d_we[0]) led_d[15:8] = d_dout[15:8];
        if (led_wr && d_we[1]) led_d[7:0]  = d_dout[7:0];

        // Any lane write freezes the other lane for that cycle instead of
        // letting it tick.
        timer_d = timer_q + 16'd1;
        if (timer_wr) begin
            timer_d = timer_q;
            if (d_we[0]) timer_d[15:8] = d_dout[15:8];
            if (d_we[1]) timer_d[7:0]  = d_dout[7:0];
        end

        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A dropped push wins over a same-cycle clear.
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q    <= 16'h0000;
            timer_q  <= 16'h0000;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            led_q    <= led_d;
            timer_q  <= timer_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; the count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= d_dout;
    end

endmodule
